mem_port_arbiter: RTL

//  Shares the core's single external memory port between the IF stage (instruction fetch) and
//  the MEM stage (loads/stores). One transaction in flight; MEM has fixed priority over IF.

---
 rtl/mem_port_arbiter_pkg.sv | 14 +
 rtl/mem_port_arbiter_if.sv | 52 +++++
 rtl/mem_port_arbiter_timer.sv | 27 ++
 rtl/mem_port_arbiter.sv | 111 +++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the memory port arbiter.
//   arb_state_t : arbiter FSM encoding
//   timer_w()   : watchdog counter width for a given TIMEOUT
package mem_port_arbiter_pkg;
  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {ARB_IDLE, ARB_MEM_WAIT, ARB_IF_WAIT} arb_state_t;

  function automatic int timer_w(input int t);
    return (t < 1) ? 1 : $clog2(t + 1);
  endfunction
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of all arbiter-facing signals: IF requester, MEM requester,
// external bus.
//   slave  : arbiter view (requests/bus_ack in, responses/bus command out)
//   master : environment view (core stages + memory)
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  // instruction fetch side
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              if_stall_req;
  // load/store side
  logic                mem_req;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_be;
  logic [DATA_W-1:0]   mem_rdata;
  logic                mem_valid;
  logic                mem_stall_req;
  // external bus
  logic                bus_req;
  logic                bus_we;
  logic [ADDR_W-1:0]   bus_addr;
  logic [DATA_W-1:0]   bus_wdata;
  logic [DATA_W/8-1:0] bus_be;
  logic                bus_ack;
  logic [DATA_W-1:0]   bus_rdata;
  logic                bus_err;

  modport slave (
    input  if_req, if_addr, if_flush,
    output if_rdata, if_valid, if_stall_req,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_rdata, mem_valid, mem_stall_req,
    output bus_req, bus_we, bus_addr, bus_wdata, bus_be, bus_err,
    input  bus_ack, bus_rdata
  );

  modport master (
    output if_req, if_addr, if_flush,
    input  if_rdata, if_valid, if_stall_req,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_rdata, mem_valid, mem_stall_req,
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_be, bus_err,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_port_arbiter_timer.sv
// Bus watchdog counter.
//   clk, reset : clock, async active-low reset
//   clr        : restart from 0 (takes priority over en)
//   en         : count this cycle
//   expired    : count has reached TIMEOUT (counter holds there)
module mem_arb_timer
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  localparam int W = timer_w(TIMEOUT)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [W-1:0] cnt;

  assign expired = (cnt == W'(TIMEOUT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)             cnt <= '0;
    else if (clr)           cnt <= '0;
    else if (en && !expired) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single external memory port between instruction fetch and
// the MEM stage. One transaction in flight, MEM has fixed priority.
//   clk, reset : clock, async active-low reset
//   arb        : interface (slave view) carrying IF/MEM requests and
//                responses, stall requests and the external bus
// Responses (valid/rdata/bus_err) are combinational from the completing
// cycle; the bus command and bus_req are registered.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = mem_port_arbiter_pkg::ADDR_W,
  parameter int DATA_W  = mem_port_arbiter_pkg::DATA_W,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic            clk,
  input logic            reset,
  mem_port_arbiter_if.slave arb
);
  arb_state_t          state;
  logic                discard;
  logic                bus_req_q, bus_we_q;
  logic [ADDR_W-1:0]   bus_addr_q;
  logic [DATA_W-1:0]   bus_wdata_q;
  logic [DATA_W/8-1:0] bus_be_q;

  logic in_wait, grant_mem, grant_if, tmo_hit, ack, abort, done;
  logic mem_vld, if_vld;

  assign in_wait   = (state != ARB_IDLE);
  assign grant_mem = (state == ARB_IDLE) && arb.mem_req;
  // a flush in IDLE only blocks this cycle's fetch grant
  assign grant_if  = (state == ARB_IDLE) && !arb.mem_req && arb.if_req && !arb.if_flush;

  mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (grant_mem || grant_if),
    .en      (in_wait),
    .expired (tmo_hit)
  );

  // ack beats a same-cycle timeout; bus_ack outside a wait state is ignored
  assign ack   = in_wait && arb.bus_ack;
  assign abort = in_wait && tmo_hit && !arb.bus_ack;
  assign done  = ack || abort;

  assign mem_vld = (state == ARB_MEM_WAIT) && done;
  assign if_vld  = (state == ARB_IF_WAIT) && done && !(discard || arb.if_flush);

  assign arb.mem_valid = mem_vld;
  assign arb.mem_rdata = ((state == ARB_MEM_WAIT) && ack) ? arb.bus_rdata : '0;
  assign arb.if_valid  = if_vld;
  assign arb.if_rdata  = ((state == ARB_IF_WAIT) && ack) ? arb.bus_rdata : '0;
  assign arb.bus_err   = abort;

  assign arb.mem_stall_req = arb.mem_req && !mem_vld;
  assign arb.if_stall_req  = (arb.if_req && !if_vld) || arb.mem_stall_req;

  assign arb.bus_req   = bus_req_q;
  assign arb.bus_we    = bus_we_q;
  assign arb.bus_addr  = bus_addr_q;
  assign arb.bus_wdata = bus_wdata_q;
  assign arb.bus_be    = bus_be_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ARB_IDLE;
      discard     <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_be_q    <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (grant_mem) begin
            state       <= ARB_MEM_WAIT;
            bus_req_q   <= 1'b1;
            bus_we_q    <= arb.mem_we;
            bus_addr_q  <= arb.mem_addr;
            bus_wdata_q <= arb.mem_wdata;
            bus_be_q    <= arb.mem_be;
          end else if (grant_if) begin
            state       <= ARB_IF_WAIT;
            bus_req_q   <= 1'b1;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= arb.if_addr;
            bus_wdata_q <= '0;
            bus_be_q    <= '1;
          end
        end
        ARB_MEM_WAIT, ARB_IF_WAIT: begin
          if (done) begin
            state     <= ARB_IDLE;
            bus_req_q <= 1'b0;
          end
        end
        default: begin
          state     <= ARB_IDLE;
          bus_req_q <= 1'b0;
        end
      endcase

      // a killed fetch still runs to completion on the bus; only its
      // response is dropped
      if (state == ARB_IF_WAIT && !done) discard <= discard || arb.if_flush;
      else                               discard <= 1'b0;
    end
  end
endmodule
